// File: rtl/group_scan_host_if_if.sv
// Command, response and static scan bus signals of one group mux port.
// master: the host-side initiator; slave: the command source plus scan responder.
interface group_scan_host_if_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [19:0] cmd_addr;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        static_wen_group_mux;
    logic        static_ren_group_mux;
    logic [19:0] static_addr_group_mux;
    logic [31:0] static_wdata_group_mux;
    logic [31:0] static_rdata_group_mux;
    logic        static_ready_group_mux;
    logic        scan_id_group_mux;
    logic        busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               static_rdata_group_mux, static_ready_group_mux,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               static_wen_group_mux, static_ren_group_mux, static_addr_group_mux,
               static_wdata_group_mux, scan_id_group_mux, busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               static_rdata_group_mux, static_ready_group_mux,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               static_wen_group_mux, static_ren_group_mux, static_addr_group_mux,
               static_wdata_group_mux, scan_id_group_mux, busy
    );
endinterface

// File: rtl/group_scan_host_if.sv
// Group static scan bus initiator: one command -> setup, scan_id/ready 4-phase handshake, response.
// Optional handshake watchdog enabled by defining GROUP_SCAN_TIMEOUT_EN.
module group_scan_host_if #(
    parameter int SETUP_CYC   = 2,
    parameter int SYNC_STAGES = 2
`ifdef GROUP_SCAN_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    group_scan_host_if_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        REQ,
        RELEASE,
        RESP
    } state_t;

    localparam int SETUP_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(SETUP_CYC - 1);

    state_t             state_reg, state_next;
    logic [SETUP_W-1:0] setup_cnt_reg, setup_cnt_next;
    logic               armed_reg, armed_next;
    logic               scan_id_reg;
    logic               wen_reg, wen_next;
    logic               ren_reg, ren_next;
    logic [19:0]        addr_reg, addr_next;
    logic [31:0]        wdata_reg, wdata_next;
    logic [31:0]        rdata_reg, rdata_next;
    logic               err_reg, err_next;
    logic               cmd_ready_c;
    logic               rsp_valid_c;
    logic               idle_open;
    logic               rdy_s;

    // Ready comes from another domain; only the last stage is ever looked at.
    logic [SYNC_STAGES:0] sync_chain;
    assign sync_chain[0] = bus.static_ready_group_mux;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic stage_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_reg <= 1'b0;
                end else begin
                    stage_reg <= sync_chain[gi];
                end
            end
            assign sync_chain[gi+1] = stage_reg;
        end
    endgenerate

    assign rdy_s = sync_chain[SYNC_STAGES];

`ifdef GROUP_SCAN_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] wd_reg, wd_next;
    // A responder still holding ready after a timeout must drop it before the next command.
    assign idle_open = ~rdy_s;
`else
    assign idle_open = 1'b1;
`endif

    always_comb begin
        state_next     = state_reg;
        setup_cnt_next = setup_cnt_reg;
        armed_next     = armed_reg;
        wen_next       = wen_reg;
        ren_next       = ren_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        rdata_next     = rdata_reg;
        err_next       = err_reg;
        cmd_ready_c    = 1'b0;
        rsp_valid_c    = 1'b0;
`ifdef GROUP_SCAN_TIMEOUT_EN
        wd_next        = wd_reg;
`endif
        case (state_reg)
            IDLE: begin
                cmd_ready_c = idle_open;
                if (bus.cmd_valid && idle_open) begin
                    addr_next      = bus.cmd_addr;
                    wdata_next     = bus.cmd_wdata;
                    wen_next       = bus.cmd_write;
                    ren_next       = ~bus.cmd_write;
                    err_next       = 1'b0;
                    setup_cnt_next = '0;
                    state_next     = SETUP;
                end
            end
            SETUP: begin
                if (setup_cnt_reg == SETUP_LAST) begin
                    armed_next = 1'b0;
                    state_next = REQ;
`ifdef GROUP_SCAN_TIMEOUT_EN
                    wd_next    = '0;
`endif
                end else begin
                    setup_cnt_next = setup_cnt_reg + 1'b1;
                end
            end
            REQ: begin
                // Only a 0->1 seen inside REQ counts, so a stale ready cannot complete the transfer.
                if (armed_reg && rdy_s) begin
                    rdata_next = ren_reg ? bus.static_rdata_group_mux : 32'h0;
                    wen_next   = 1'b0;
                    ren_next   = 1'b0;
                    state_next = RELEASE;
`ifdef GROUP_SCAN_TIMEOUT_EN
                    wd_next    = '0;
`endif
                end else begin
                    if (!rdy_s) begin
                        armed_next = 1'b1;
                    end
`ifdef GROUP_SCAN_TIMEOUT_EN
                    if (wd_reg == WD_LAST) begin
                        wen_next   = 1'b0;
                        ren_next   = 1'b0;
                        rdata_next = 32'h0;
                        err_next   = 1'b1;
                        state_next = RESP;
                    end else begin
                        wd_next = wd_reg + 16'd1;
                    end
`endif
                end
            end
            RELEASE: begin
                if (!rdy_s) begin
                    state_next = RESP;
                end else begin
`ifdef GROUP_SCAN_TIMEOUT_EN
                    if (wd_reg == WD_LAST) begin
                        rdata_next = 32'h0;
                        err_next   = 1'b1;
                        state_next = RESP;
                    end else begin
                        wd_next = wd_reg + 16'd1;
                    end
`endif
                end
            end
            RESP: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            setup_cnt_reg <= '0;
            armed_reg     <= 1'b0;
            scan_id_reg   <= 1'b0;
            wen_reg       <= 1'b0;
            ren_reg       <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            setup_cnt_reg <= setup_cnt_next;
            armed_reg     <= armed_next;
            // Registered so the responder sees a glitch-free request level.
            scan_id_reg   <= (state_next == REQ);
            wen_reg       <= wen_next;
            ren_reg       <= ren_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            rdata_reg     <= rdata_next;
            err_reg       <= err_next;
        end
    end

`ifdef GROUP_SCAN_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_reg <= '0;
        end else begin
            wd_reg <= wd_next;
        end
    end
    assign bus.rsp_err = err_reg;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.cmd_ready              = cmd_ready_c;
    assign bus.rsp_valid              = rsp_valid_c;
    assign bus.rsp_rdata              = rdata_reg;
    assign bus.static_wen_group_mux   = wen_reg;
    assign bus.static_ren_group_mux   = ren_reg;
    assign bus.static_addr_group_mux  = addr_reg;
    assign bus.static_wdata_group_mux = wdata_reg;
    assign bus.scan_id_group_mux      = scan_id_reg;
    assign bus.busy                   = (state_reg != IDLE);

endmodule

// File: tb/tb_group_scan_host_if.sv
// Bench for group_scan_host_if: memory-like scan responder plus a memory reference model.
// Timeout scenario is built only when GROUP_SCAN_TIMEOUT_EN is defined.
module tb_group_scan_host_if;
    localparam int SETUP_CYC   = 2;
    localparam int SYNC_STAGES = 2;
    localparam int RUN_BOUND   = 400;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    group_scan_host_if_if bus ();

`ifdef GROUP_SCAN_TIMEOUT_EN
    group_scan_host_if #(.SETUP_CYC(SETUP_CYC), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`else
    group_scan_host_if #(.SETUP_CYC(SETUP_CYC), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`endif

    always #5 clk = ~clk;

    // Responder knobs and storage; the model keeps its own copy of memory contents.
    int          resp_delay  = 3;
    int          rel_delay   = 1;
    bit          never_ready = 1'b0;
    logic [31:0] resp_mem  [int];
    logic [31:0] model_mem [int];

    function automatic logic [31:0] dflt(input logic [19:0] a);
        return {12'hC3A, a} ^ 32'h0000_5A5A;
    endfunction

    function automatic logic [31:0] model_apply(input logic wr, input logic [19:0] a, input logic [31:0] d);
        if (wr) begin
            model_mem[int'(a)] = d;
            return 32'h0;
        end
        return model_mem.exists(int'(a)) ? model_mem[int'(a)] : dflt(a);
    endfunction

    // Bus monitor: snapshot at each scan_id rise, setup length, overlap of scan_id and rsp_valid.
    int          scan_rises   = 0;
    int          setup_run    = 0;
    bit          overlap_seen = 1'b0;
    logic        prev_scan    = 1'b0;
    logic [19:0] snap_addr    = '0;
    logic [31:0] snap_wdata   = '0;
    logic        snap_wen     = 1'b0;
    logic        snap_ren     = 1'b0;
    int          snap_setup   = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.scan_id_group_mux && !prev_scan) begin
                snap_addr  = bus.static_addr_group_mux;
                snap_wdata = bus.static_wdata_group_mux;
                snap_wen   = bus.static_wen_group_mux;
                snap_ren   = bus.static_ren_group_mux;
                snap_setup = setup_run;
                scan_rises++;
                if (bus.static_wen_group_mux)
                    resp_mem[int'(bus.static_addr_group_mux)] = bus.static_wdata_group_mux;
            end
            if (!bus.scan_id_group_mux && (bus.static_wen_group_mux || bus.static_ren_group_mux))
                setup_run++;
            else
                setup_run = 0;
            if (bus.scan_id_group_mux && bus.rsp_valid) overlap_seen = 1'b1;
            prev_scan = bus.scan_id_group_mux;
        end
    end

    initial begin
        int cnt;
        int rel;
        int a;
        cnt = 0;
        rel = 0;
        bus.static_ready_group_mux = 1'b0;
        bus.static_rdata_group_mux = '0;
        forever begin
            @(negedge clk);
            if (!bus.static_ready_group_mux) begin
                if (bus.scan_id_group_mux && !never_ready) begin
                    cnt++;
                    if (cnt >= resp_delay) begin
                        a = int'(bus.static_addr_group_mux);
                        bus.static_rdata_group_mux = resp_mem.exists(a) ? resp_mem[a] : dflt(bus.static_addr_group_mux);
                        bus.static_ready_group_mux = 1'b1;
                        rel = 0;
                    end
                end else begin
                    cnt = 0;
                end
            end else if (!bus.scan_id_group_mux) begin
                rel++;
                if (rel >= rel_delay) begin
                    bus.static_ready_group_mux = 1'b0;
                    cnt = 0;
                end
            end
        end
    end

    // Drives one command, waits (bounded) for its response, holds rsp_ready low for 'hold' cycles.
    task automatic run_cmd(input logic wr, input logic [19:0] a, input logic [31:0] d, input int hold,
                           output logic [31:0] rd, output logic er, output bit ok, output int hold_bad);
        bit acc;
        bit got;
        logic [31:0] first;
        ok = 1'b0; rd = '0; er = 1'b0; hold_bad = 0; acc = 1'b0; got = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_wdata = d;
        for (int i = 0; i < RUN_BOUND && !acc; i++) begin
            if (bus.cmd_ready) acc = 1'b1;
            else @(negedge clk);
        end
        if (!acc) begin
            bus.cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < RUN_BOUND && !got; i++) begin
            if (bus.rsp_valid) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) return;
        first = bus.rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== first || bus.cmd_ready !== 1'b0) hold_bad++;
        end
        rd = bus.rsp_rdata; er = bus.rsp_err; bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        ok = 1'b1;
        $display("txn wr=%0d addr=%05h wdata=%08h rdata=%08h err=%0d", wr, a, d, rd, er);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b want=1", bus.cmd_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid); end
        checks++; if (bus.scan_id_group_mux !== 1'b0) begin failures++; $display("FAIL reset_scan_id got=%b want=0", bus.scan_id_group_mux); end
        checks++; if (bus.static_wen_group_mux !== 1'b0 || bus.static_ren_group_mux !== 1'b0) begin
            failures++; $display("FAIL reset_wen_ren got=%b%b want=00", bus.static_wen_group_mux, bus.static_ren_group_mux); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
            failures++; $display("FAIL reset_rsp got=%h/%b want=0/0", bus.rsp_rdata, bus.rsp_err); end
        checks++; if (bus.static_addr_group_mux !== 20'h0 || bus.static_wdata_group_mux !== 32'h0) begin
            failures++; $display("FAIL reset_bus got=%h/%h want=0/0", bus.static_addr_group_mux, bus.static_wdata_group_mux); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        logic [31:0] rd, exp;
        logic er;
        bit ok;
        int hb;
        resp_delay = 3;
        exp = model_apply(1'b1, 20'h00105, 32'hA5A5_0001);
        run_cmd(1'b1, 20'h00105, 32'hA5A5_0001, 0, rd, er, ok, hb);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL write_done got=%0d want=1", ok); end
        checks++; if (rd !== exp || er !== 1'b0) begin failures++; $display("FAIL write_rsp got=%h/%b want=%h/0", rd, er, exp); end
        checks++; if (snap_wen !== 1'b1 || snap_ren !== 1'b0) begin failures++; $display("FAIL write_strobes got=%b%b want=10", snap_wen, snap_ren); end
        checks++; if (snap_addr !== 20'h00105 || snap_wdata !== 32'hA5A5_0001) begin
            failures++; $display("FAIL write_bus got=%h/%h want=00105/a5a50001", snap_addr, snap_wdata); end
        checks++; if (snap_setup !== SETUP_CYC) begin failures++; $display("FAIL write_setup got=%0d want=%0d", snap_setup, SETUP_CYC); end
    endtask

    task automatic test_read();
        logic [31:0] rd, exp;
        logic er;
        bit ok;
        int hb;
        resp_mem[int'(20'h00402)]  = 32'h0000_07FF;
        model_mem[int'(20'h00402)] = 32'h0000_07FF;
        overlap_seen = 1'b0;
        exp = model_apply(1'b0, 20'h00402, 32'h0);
        run_cmd(1'b0, 20'h00402, 32'h0, 0, rd, er, ok, hb);
        checks++; if (ok !== 1'b1 || rd !== exp) begin failures++; $display("FAIL read_data got=%h want=%h", rd, exp); end
        checks++; if (snap_ren !== 1'b1 || snap_wen !== 1'b0) begin failures++; $display("FAIL read_strobes got=%b%b want=01", snap_wen, snap_ren); end
        checks++; if (overlap_seen !== 1'b0) begin failures++; $display("FAIL read_scan_overlap got=%b want=0", overlap_seen); end
        checks++; if (snap_setup !== SETUP_CYC) begin failures++; $display("FAIL read_setup got=%0d want=%0d", snap_setup, SETUP_CYC); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w, exp_r, rd1, rd2;
        int acc_n, rsp_hs, hs_at_second, rises0;
        logic scan_at_second;
        bit done;
        acc_n = 0; rsp_hs = 0; hs_at_second = -1; scan_at_second = 1'bx; done = 1'b0;
        rd1 = 'x; rd2 = 'x;
        resp_delay = 2; rel_delay = 2;
        exp_w = model_apply(1'b1, 20'h00777, 32'h1234_5678);
        exp_r = model_apply(1'b0, 20'h00777, 32'h0);
        rises0 = scan_rises;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 20'h00777; bus.cmd_wdata = 32'h1234_5678;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 2 * RUN_BOUND && !done; i++) begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                acc_n++;
                if (acc_n == 2) begin
                    hs_at_second   = rsp_hs;
                    scan_at_second = bus.scan_id_group_mux;
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_hs++;
                if (rsp_hs == 1) rd1 = bus.rsp_rdata;
                if (rsp_hs == 2) begin rd2 = bus.rsp_rdata; done = 1'b1; end
            end
            @(negedge clk);
            if (acc_n == 1) begin bus.cmd_write = 1'b0; bus.cmd_wdata = 32'h0; end
            if (acc_n == 2) bus.cmd_valid = 1'b0;
        end
        bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
        $display("txn b2b write+read addr=00777 rdata1=%08h rdata2=%08h", rd1, rd2);
        checks++; if (done !== 1'b1 || acc_n !== 2) begin failures++; $display("FAIL b2b_done got=%0d/%0d want=1/2", done, acc_n); end
        checks++; if (hs_at_second !== 1) begin failures++; $display("FAIL b2b_accept_order got=%0d want=1", hs_at_second); end
        checks++; if (scan_at_second !== 1'b0) begin failures++; $display("FAIL b2b_scan_between got=%b want=0", scan_at_second); end
        checks++; if (rd1 !== exp_w || rd2 !== exp_r) begin failures++; $display("FAIL b2b_data got=%h/%h want=%h/%h", rd1, rd2, exp_w, exp_r); end
        checks++; if (scan_rises - rises0 !== 2) begin failures++; $display("FAIL b2b_scan_rises got=%0d want=2", scan_rises - rises0); end
        resp_delay = 3; rel_delay = 1;
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, exp;
        logic er;
        bit ok;
        int hb;
        exp = model_apply(1'b0, 20'h00105, 32'h0);
        run_cmd(1'b0, 20'h00105, 32'h0, 20, rd, er, ok, hb);
        checks++; if (ok !== 1'b1 || rd !== exp) begin failures++; $display("FAIL bp_data got=%h want=%h", rd, exp); end
        checks++; if (hb !== 0) begin failures++; $display("FAIL bp_stable bad_cycles=%0d want=0", hb); end
    endtask

`ifdef GROUP_SCAN_TIMEOUT_EN
    task automatic test_timeout();
        int scan_cnt;
        bit acc, got;
        logic [31:0] rd;
        logic er;
        scan_cnt = 0; acc = 1'b0; got = 1'b0; rd = 'x; er = 1'bx;
        never_ready = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 20'h00402;
        for (int i = 0; i < RUN_BOUND && !acc; i++) begin
            if (bus.cmd_ready) acc = 1'b1; else @(negedge clk);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < RUN_BOUND && !got; i++) begin
            if (bus.rsp_valid) got = 1'b1;
            else begin
                if (bus.scan_id_group_mux) scan_cnt++;
                @(negedge clk);
            end
        end
        rd = bus.rsp_rdata; er = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        $display("txn timeout read addr=00402 rdata=%08h err=%0d scan_cycles=%0d", rd, er, scan_cnt);
        checks++; if (got !== 1'b1 || er !== 1'b1) begin failures++; $display("FAIL to_err got=%b want=1", er); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL to_rdata got=%h want=0", rd); end
        checks++; if (scan_cnt !== 16) begin failures++; $display("FAIL to_req_cycles got=%0d want=16", scan_cnt); end
        checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL to_cmd_ready got=%b want=1", bus.cmd_ready); end
        never_ready = 1'b0;
    endtask
`endif

    task automatic test_reset_in_req();
        bit acc, in_req;
        int rsp_seen;
        acc = 1'b0; in_req = 1'b0; rsp_seen = 0;
        never_ready = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 20'h00402;
        for (int i = 0; i < RUN_BOUND && !acc; i++) begin
            if (bus.cmd_ready) acc = 1'b1; else @(negedge clk);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < RUN_BOUND && !in_req; i++) begin
            if (bus.scan_id_group_mux) in_req = 1'b1; else @(negedge clk);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("txn reset during request addr=00402");
        checks++; if (in_req !== 1'b1) begin failures++; $display("FAIL rreq_reached got=%b want=1", in_req); end
        checks++; if (bus.scan_id_group_mux !== 1'b0 || bus.static_wen_group_mux !== 1'b0 || bus.static_ren_group_mux !== 1'b0) begin
            failures++; $display("FAIL rreq_bus got=%b%b%b want=000", bus.scan_id_group_mux, bus.static_wen_group_mux, bus.static_ren_group_mux); end
        checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rreq_cmd_ready got=%b want=1", bus.cmd_ready); end
        for (int i = 0; i < 10; i++) begin
            if (bus.rsp_valid) rsp_seen++;
            @(negedge clk);
        end
        checks++; if (rsp_seen !== 0) begin failures++; $display("FAIL rreq_no_rsp got=%0d want=0", rsp_seen); end
        never_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] rd, exp, d;
        logic [19:0] a;
        logic wr, er;
        bit ok;
        int hb;
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1));
            a = 20'h00100 + 20'($urandom_range(0, 7));
            d = $urandom;
            resp_delay = $urandom_range(1, 6);
            rel_delay = $urandom_range(1, 3);
            exp = model_apply(wr, a, d);
            run_cmd(wr, a, d, $urandom_range(0, 3), rd, er, ok, hb);
            checks++; if (ok !== 1'b1 || rd !== exp) begin failures++; $display("FAIL rand_data n=%0d got=%h want=%h", n, rd, exp); end
            checks++; if (er !== 1'b0 || hb !== 0) begin failures++; $display("FAIL rand_err n=%0d got=%b/%0d want=0/0", n, er, hb); end
            checks++; if (snap_addr !== a || snap_wen !== wr || snap_ren !== !wr) begin
                failures++; $display("FAIL rand_bus n=%0d got=%h/%b%b want=%h/%b%b", n, snap_addr, snap_wen, snap_ren, a, wr, !wr); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_backpressure();
`ifdef GROUP_SCAN_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_in_req();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
